// File: rtl/key_demux_pkg.sv
// rtl/key_demux_pkg.sv - shared types and constants for the keyed stream demultiplexer
package key_demux_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_e;

    localparam int MISS_CNT_W = 8;
    localparam logic [MISS_CNT_W-1:0] MISS_CNT_MAX = '1;

endpackage

// File: rtl/key_demux_if.sv
// rtl/key_demux_if.sv - keyed input stream and per-channel output streams of key_demux
interface key_demux_if #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [KEY_LEN-1:0]         in_key;
    logic [DATA_LEN-1:0]        in_data;
    logic [NR_KEY-1:0]          out_valid;
    logic [NR_KEY-1:0]          out_ready;
    logic [NR_KEY*DATA_LEN-1:0] out_data;

    // producer / consumers side
    modport master (
        output in_valid, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // demultiplexer side
    modport slave (
        input  in_valid, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/key_demux_slot.sv
// rtl/key_demux_slot.sv - two-entry channel FIFO with registered head
module key_demux_slot
    import key_demux_pkg::*;
#(
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_LEN-1:0] push_data,
    input  logic                pop,
    output logic                valid,
    output logic                full,
    output logic [DATA_LEN-1:0] head_data
);

    slot_state_e         state_q;
    logic [DATA_LEN-1:0] head_q;
    logic [DATA_LEN-1:0] tail_q;
    logic                push_ok;
    logic                pop_ok;

    // a pop on an empty slot or a push into a full one is ignored
    assign pop_ok  = pop  & (state_q != SLOT_EMPTY);
    assign push_ok = push & (state_q != SLOT_FULL);

    // occupancy state and the two storage words; head is always the oldest word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (push_ok) begin
                        head_q  <= push_data;
                        state_q <= SLOT_ONE;
                    end
                end
                SLOT_ONE: begin
                    case ({push_ok, pop_ok})
                        2'b10: begin
                            tail_q  <= push_data;
                            state_q <= SLOT_FULL;
                        end
                        2'b01: state_q <= SLOT_EMPTY;
                        2'b11: head_q  <= push_data;
                        default: ;
                    endcase
                end
                SLOT_FULL: begin
                    if (pop_ok) begin
                        head_q  <= tail_q;
                        state_q <= SLOT_ONE;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid     = (state_q != SLOT_EMPTY);
    assign full      = (state_q == SLOT_FULL);
    assign head_data = head_q;

endmodule

// File: rtl/key_demux.sv
// rtl/key_demux.sv - keyed stream demultiplexer; KEY_DEMUX_MISS_CNT_EN adds a saturating miss counter
module key_demux
    import key_demux_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NR_KEY*KEY_LEN-1:0] key_lut,
    key_demux_if.slave                bus,
`ifdef KEY_DEMUX_MISS_CNT_EN
    output logic [MISS_CNT_W-1:0]     miss_cnt,
`endif
    output logic                      miss
);

    logic [NR_KEY-1:0] hit;
    logic [NR_KEY-1:0] sel;
    logic [NR_KEY-1:0] slot_full;
    logic [NR_KEY-1:0] slot_push;
    logic [NR_KEY-1:0] slot_pop;
    logic              accept;
    logic              miss_evt;
    logic              miss_q;
    logic              miss_d;

    // key compare against every programmed channel key
    always_comb begin
        hit = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            hit[n] = (bus.in_key == key_lut[n*KEY_LEN +: KEY_LEN]);
        end
    end

    // isolate the lowest-index hit so duplicate keys route to the first channel only
    assign sel = hit & (~hit + NR_KEY'(1));

    // ready only looks at registered slot state, never at out_ready; misses always pass
    assign bus.in_ready = ~rst & ~(|(sel & slot_full));
    assign accept       = bus.in_valid & bus.in_ready;
    assign miss_evt     = accept & ~(|hit);
    assign slot_push    = sel & {NR_KEY{accept}};
    assign slot_pop     = bus.out_valid & bus.out_ready;

    genvar g;
    generate
        for (g = 0; g < NR_KEY; g++) begin : g_slot
            key_demux_slot #(
                .DATA_LEN (DATA_LEN)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .push      (slot_push[g]),
                .push_data (bus.in_data),
                .pop       (slot_pop[g]),
                .valid     (bus.out_valid[g]),
                .full      (slot_full[g]),
                .head_data (bus.out_data[g*DATA_LEN +: DATA_LEN])
            );
        end
    endgenerate

    assign miss_d = miss_q | miss_evt;

    // sticky miss flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_q <= 1'b0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss = miss_q;

`ifdef KEY_DEMUX_MISS_CNT_EN
    logic [MISS_CNT_W-1:0] miss_cnt_q;
    logic [MISS_CNT_W-1:0] miss_cnt_d;

    assign miss_cnt_d = (miss_evt && miss_cnt_q != MISS_CNT_MAX) ? miss_cnt_q + MISS_CNT_W'(1)
                                                                 : miss_cnt_q;

    // saturating count of accepted misses
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/key_demux.md
# key_demux

Keyed stream demultiplexer, the inverse of the keyed lookup mux: one valid/ready input stream carries a key and a data word, and the block routes each word to the output channel whose programmed key matches. Each channel has a two-entry buffer, so backpressure on one channel does not stall traffic to the others until that channel fills. It sits between a single producer (decoder, bus front end) and NR_KEY independent consumers.

## Interface
- NR_KEY, 4: number of output channels.
- KEY_LEN, 2: key width in bits.
- DATA_LEN, 8: data word width in bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_lut  input  NR_KEY*KEY_LEN  channel n's key in bits [KEY_LEN*(n+1)-1 : KEY_LEN*n]; quasi-static.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_key  input  KEY_LEN  routing key.
- in_data  input  DATA_LEN  payload.
- out_valid  output  NR_KEY  bit n: channel n head entry valid.
- out_ready  input  NR_KEY  bit n: consumer n takes the head this cycle.
- out_data  output  NR_KEY*DATA_LEN  channel n head in bits [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- miss  output  1  sticky: a word with no matching key was accepted.
- miss_cnt  output  8  only with KEY_DEMUX_MISS_CNT_EN; saturating miss count.

## Operation
- Lookup: hit[n] = (in_key == key_n). Target is the lowest-index hit. Duplicate keys in key_lut are legal; higher-index duplicates never receive data.
- Each channel is a 2-entry FIFO. Its state is EMPTY, ONE or FULL.
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: ONE->EMPTY, FULL->ONE.
  - push and pop together: state unchanged; ONE shifts the new word in behind the departing head.
- in_ready:
  - Matched key: in_ready = 1 when the target channel is not FULL.
  - No match: in_ready = 1 always, so misses are never stalled.
  - in_ready depends only on in_key, key_lut and registered state. It does not depend on out_ready, so there is no combinational ready path from output to input.
- Transfer on the input occurs when in_valid & in_ready.
  - Hit: push in_data into the target channel.
  - Miss: discard the word and set miss.
- Pop on channel n occurs when out_valid[n] & out_ready[n].
- out_valid[n] = (state != EMPTY). out_data for channel n is the head entry, registered.
- Channels are fully independent; at most one channel is pushed per cycle.
- out_ready[n] while out_valid[n] = 0 has no effect.
- Word order within a channel is preserved.

## Timing
- Reset (rst high at an edge) forces:
  - every channel to EMPTY, so out_valid = 0;
  - out_data = 0;
  - miss = 0 and miss_cnt = 0.
- Reset mid-operation discards all buffered words.
- in_ready is 0 while rst is high.
- Latency: a word accepted at edge t appears on out_valid/out_data of an EMPTY channel after edge t, i.e. one cycle.
- Throughput: one word per cycle, provided the target channel's consumer keeps out_ready high.
- FULL with simultaneous pop: in_ready stays 0 in that cycle (registered-state rule). Acceptance resumes the next cycle.
- The input side may hold in_valid with in_ready low indefinitely. The producer must keep in_key/in_data stable until the transfer completes.

## Configuration
- KEY_DEMUX_MISS_CNT_EN defined:
  - Port miss_cnt exists.
  - It increments by 1 on every accepted miss and saturates at 255.
  - It is cleared only by reset.
- Undefined: the port and counter are absent; only the sticky miss flag is present.

## Structure
- Package key_demux_pkg holds:
  - the slot-state type (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - the miss-counter width constant (8).
- Sub-module key_demux_slot: one 2-entry channel FIFO.
  - Ports: clk, rst, push, push_data, pop, valid, full, head_data.
  - Instantiated NR_KEY times in a generate loop.
- Top level holds the key compare, lowest-index select, in_ready mux and miss logic.

## Test plan
- Reset: drive rst for 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, miss=0; after release out_valid stays 0 until the first transfer.
- Routing, with key_lut = {2'd3,2'd2,2'd1,2'd0} and out_ready=4'b1111: send key 2 data 8'hA5 -> out_valid=4'b0100 one cycle later, channel 2 data 8'hA5.
- Backpressure, with out_ready[1]=0: send 8'h11, 8'h22, 8'h33 to key 1 -> first two accepted, in_ready=0 for the third. Meanwhile key 0 word 8'h44 is still accepted. Raising out_ready[1] drains 8'h11 then 8'h22 in order, then 8'h33 is accepted.
- Duplicate keys, with key_lut = {2'd1,2'd1,2'd1,2'd1}: send key 1 data 8'h5A -> only channel 0 valid. Send key 0 -> accepted immediately, miss=1, no out_valid.
- Simultaneous push/pop on a ONE channel, out_ready=1, back-to-back words 8'h01..8'h04 on key 3 -> channel 3 emits 01,02,03,04 on consecutive cycles and never reaches FULL.
- With KEY_DEMUX_MISS_CNT_EN: 300 consecutive unmatched words -> miss_cnt=255. Reset -> miss_cnt=0.
